regfile_write_arbiter: RTL

Shares the register file's single write port (RW, BusW, RegWr) among several writeback requesters, such as ALU result, load return and link-register writes. Each cycle it picks one requester using a round-robin policy and registers the winning write toward the register file. It also publishes a one-hot pending mask so that hazard logic can see which register is about to be written.

---
 rtl/rf_pkg.sv | 10 +
 rtl/rr_pick.sv | 24 ++
 rtl/regfile_write_arbiter.sv | 64 ++++++
 3 files changed

// File: rtl/rf_pkg.sv
// rf_pkg: shared register-file write constants and command type
package rf_pkg;
  localparam int RF_AW = 5;
  localparam int RF_DW = 32;
  localparam int RF_ZERO_REG = 0;
  typedef struct packed {
    logic [RF_AW-1:0] addr;
    logic [RF_DW-1:0] data;
  } wr_cmd_t;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: round-robin priority picker, first valid at or after the pointer
module rr_pick #(
  parameter int NREQ = 4,
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] i_valid,
  input  logic [PW-1:0]   i_ptr,
  output logic [PW-1:0]   o_idx,
  output logic            o_found
);
  function automatic logic [PW-1:0] wrap(input int v);
    return PW'(v % NREQ);
  endfunction
  // walk the rotated window backwards so the entry closest to the pointer wins
  always_comb begin
    o_idx = '0;
    o_found = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--)
      if (i_valid[wrap(int'(i_ptr) + k)]) begin
        o_idx = wrap(int'(i_ptr) + k);
        o_found = 1'b1;
      end
  end
endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: round-robin sharing of the register file write port
module regfile_write_arbiter
  import rf_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int AW = RF_AW,
  parameter int DW = RF_DW
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [NREQ-1:0]      ReqValid,
  input  logic [NREQ*AW-1:0]   ReqRW,
  input  logic [NREQ*DW-1:0]   ReqBusW,
  output logic [NREQ-1:0]      ReqReady,
  input  logic                 Hold,
  output logic [AW-1:0]        RW,
  output logic [DW-1:0]        BusW,
  output logic                 RegWr,
  output logic [(2**AW)-1:0]   Pending
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int NP = 2 ** AW;
  logic [PW-1:0] r_ptr, w_win, w_ptr_nxt;
  logic          w_found, w_xfer;
  logic [AW-1:0] w_rw_a [NREQ];
  logic [DW-1:0] w_dw_a [NREQ];
  logic [AW-1:0] w_rw, r_rw;
  logic [DW-1:0] w_dw, r_busw;
  logic          r_regwr;
  for (genvar i = 0; i < NREQ; i++) begin : g_slice
    assign w_rw_a[i] = ReqRW[i*AW +: AW];
    assign w_dw_a[i] = ReqBusW[i*DW +: DW];
  end
  rr_pick #(.NREQ(NREQ)) u_pick (
    .i_valid(ReqValid),
    .i_ptr  (r_ptr),
    .o_idx  (w_win),
    .o_found(w_found)
  );
  assign w_xfer    = w_found && !Hold && !Reset;
  assign ReqReady  = w_xfer ? NREQ'(1) << w_win : '0;
  assign w_rw      = w_rw_a[w_win];
  assign w_dw      = w_dw_a[w_win];
  assign w_ptr_nxt = (w_win == PW'(NREQ - 1)) ? '0 : w_win + 1'b1;
  assign RW        = r_rw;
  assign BusW      = r_busw;
  assign RegWr     = r_regwr;
  assign Pending   = r_regwr ? NP'(1) << r_rw : '0;
  // pointer and output stage; register 0 writes complete the handshake but never assert RegWr
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      r_ptr   <= '0;
      r_rw    <= '0;
      r_busw  <= '0;
      r_regwr <= 1'b0;
    end else begin
      r_regwr <= w_xfer && (w_rw != AW'(RF_ZERO_REG));
      if (w_xfer) begin
        r_ptr  <= w_ptr_nxt;
        r_rw   <= w_rw;
        r_busw <= w_dw;
      end
    end
endmodule
